// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, fetches over an AR/R handshake and hands {inst, pc} to the IDU.
// Optional IFU_ALIGN_CHK_EN: a misaligned jump target sets sticky misalign_o and parks the FSM in HALT.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_arvalid_o,
  output logic [31:0] imem_araddr_o,
  input  logic        imem_arready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic [1:0]  imem_rresp_i,
  output logic        imem_rready_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT
`ifdef IFU_ALIGN_CHK_EN
    , S_HALT
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        r_fire;
  logic        out_fire;

`ifdef IFU_ALIGN_CHK_EN
  logic        bad_target;
  assign bad_target = jump_en_i & (jump_addr_i[1:0] != 2'b00);
`endif

  assign imem_araddr_o = pc;
  assign r_fire        = (state == S_R) & imem_rvalid_i;
  assign out_fire      = (state == S_OUT) & inst_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs decode straight from state so AR and R can never overlap.
  always_comb begin
    state_nxt      = state;
    imem_arvalid_o = 1'b0;
    imem_rready_o  = 1'b0;
    inst_valid_o   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_AR;
      S_AR: begin
        imem_arvalid_o = 1'b1;
        if (imem_arready_i) state_nxt = S_R;
      end
      S_R: begin
        imem_rready_o = 1'b1;
        if (imem_rvalid_i) state_nxt = S_OUT;
      end
      S_OUT: begin
        inst_valid_o = 1'b1;
        if (inst_ready_i) begin
`ifdef IFU_ALIGN_CHK_EN
          state_nxt = bad_target ? S_HALT : S_AR;
`else
          state_nxt = S_AR;
`endif
        end
      end
`ifdef IFU_ALIGN_CHK_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inst_o      <= '0;
      inst_addr_o <= RESET_PC;
    end else begin
      if (r_fire) begin
        inst_o      <= (imem_rresp_i == 2'b00) ? imem_rdata_i : ERR_INST;
        inst_addr_o <= pc;
      end
`ifdef IFU_ALIGN_CHK_EN
      if (out_fire && !bad_target) begin
`else
      if (out_fire) begin
`endif
        pc <= jump_en_i ? jump_addr_i : pc + 32'd4;
      end
    end
  end

`ifdef IFU_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o <= 1'b0;
    end else if (out_fire && bad_target) begin
      misalign_o <= 1'b1;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for ysyx_23060332_ifu: sequential fetch, wait states, backpressure, jumps, errors, reset.
module tb_ysyx_23060332_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_arvalid_o;
  logic [31:0] imem_araddr_o;
  logic        imem_arready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [1:0]  imem_rresp_i = 2'b00;
  logic        imem_rready_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        misalign_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000), .ERR_INST(32'h0010_0073)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_arvalid_o(imem_arvalid_o), .imem_araddr_o(imem_araddr_o), .imem_arready_i(imem_arready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_rresp_i(imem_rresp_i),
    .imem_rready_o(imem_rready_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (imem_arvalid_o !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%b exp=0", imem_arvalid_o); end
    checks++; if (imem_rready_o !== 1'b0) begin errors++; $display("FAIL rst_rready got=%b exp=0", imem_rready_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
    checks++; if (inst_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL rst_inst_addr got=%h exp=80000000", inst_addr_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", misalign_o); end
    rst_n = 1'b1;
    step();
    checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h8000_0000) begin
      errors++; $display("FAIL rst_first_ar got=%b/%h exp=1/80000000", imem_arvalid_o, imem_araddr_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] data [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    imem_arready_i = 1'b1; imem_rvalid_i = 1'b1; imem_rresp_i = 2'b00; inst_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h8000_0000 + 32'(4 * k);
      imem_rdata_i = data[k];
      checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== exp_pc) begin
        errors++; $display("FAIL seq_ar%0d got=%b/%h exp=1/%h", k, imem_arvalid_o, imem_araddr_o, exp_pc); end
      step();
      checks++; if (imem_rready_o !== 1'b1 || imem_arvalid_o !== 1'b0) begin
        errors++; $display("FAIL seq_r%0d got rready=%b arvalid=%b exp 1/0", k, imem_rready_o, imem_arvalid_o); end
      step();
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== data[k] || inst_addr_o !== exp_pc) begin
        errors++; $display("FAIL seq_out%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid_o, inst_o, inst_addr_o, data[k], exp_pc); end
      step();
    end
  endtask

  task automatic test_wait_states();
    imem_arready_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h8000_000C || imem_rready_o !== 1'b0) begin
        errors++; $display("FAIL wait_ar%0d got=%b/%h/%b exp=1/8000000c/0", i, imem_arvalid_o, imem_araddr_o, imem_rready_o); end
      step();
    end
    imem_arready_i = 1'b1;
    step();
    imem_arready_i = 1'b0; imem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_rready_o !== 1'b1 || imem_arvalid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        errors++; $display("FAIL wait_r%0d got=%b/%b/%b exp=1/0/0", i, imem_rready_o, imem_arvalid_o, inst_valid_o); end
      step();
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0513;
    step();
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A0_0513 || inst_addr_o !== 32'h8000_000C) begin
      errors++; $display("FAIL wait_out got=%b/%h/%h exp=1/00a00513/8000000c", inst_valid_o, inst_o, inst_addr_o); end
    imem_arready_i = 1'b1;
    step();
    checks++; if (imem_araddr_o !== 32'h8000_0010) begin
      errors++; $display("FAIL wait_next got=%h exp=80000010", imem_araddr_o); end
  endtask

  task automatic test_backpressure();
    imem_rdata_i = 32'h1234_5678; inst_ready_i = 1'b0;
    step();
    step();
    imem_rdata_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h1234_5678 || inst_addr_o !== 32'h8000_0010 || imem_arvalid_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h/%h/%b exp=1/12345678/80000010/0", i, inst_valid_o, inst_o, inst_addr_o, imem_arvalid_o); end
      step();
    end
    inst_ready_i = 1'b1;
    step();
    checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h8000_0014) begin
      errors++; $display("FAIL bp_next got=%b/%h exp=1/80000014", imem_arvalid_o, imem_araddr_o); end
  endtask

  task automatic test_jump();
    jump_en_i = 1'b1; jump_addr_i = 32'h1234_5670;
    step();
    step();
    jump_en_i = 1'b0;
    step();
    checks++; if (imem_araddr_o !== 32'h8000_0018) begin
      errors++; $display("FAIL jmp_ignored got=%h exp=80000018", imem_araddr_o); end
    step();
    step();
    jump_en_i = 1'b1; jump_addr_i = 32'h8000_0100;
    step();
    jump_en_i = 1'b0;
    checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h8000_0100) begin
      errors++; $display("FAIL jmp_taken got=%b/%h exp=1/80000100", imem_arvalid_o, imem_araddr_o); end
    step();
    step();
    inst_ready_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h4444_0000;
    step();
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL jmp_stall got=%b exp=1", inst_valid_o); end
    inst_ready_i = 1'b1; jump_en_i = 1'b0;
    step();
    checks++; if (imem_araddr_o !== 32'h8000_0104) begin
      errors++; $display("FAIL jmp_stall_next got=%h exp=80000104", imem_araddr_o); end
  endtask

  task automatic test_err();
    imem_rresp_i = 2'b10; imem_rdata_i = 32'h0000_0013;
    step();
    step();
    checks++; if (inst_o !== 32'h0010_0073 || inst_addr_o !== 32'h8000_0104) begin
      errors++; $display("FAIL err_inst got=%h/%h exp=00100073/80000104", inst_o, inst_addr_o); end
    imem_rresp_i = 2'b00;
    step();
    checks++; if (imem_araddr_o !== 32'h8000_0108) begin
      errors++; $display("FAIL err_next got=%h exp=80000108", imem_araddr_o); end
  endtask

  task automatic test_wrap();
    imem_rdata_i = 32'h0000_0013;
    step();
    step();
    jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    step();
    jump_en_i = 1'b0;
    checks++; if (imem_araddr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump got=%h exp=fffffffc", imem_araddr_o); end
    step();
    step();
    checks++; if (inst_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", inst_addr_o); end
    step();
    checks++; if (imem_araddr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero got=%h exp=00000000", imem_araddr_o); end
    step();
    step();
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0004;
    step();
    jump_en_i = 1'b0;
    checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h0000_0004) begin
      errors++; $display("FAIL wrap_pc4 got=%b/%h exp=1/00000004", imem_arvalid_o, imem_araddr_o); end
  endtask

  task automatic test_reset_mid();
    imem_rvalid_i = 1'b0;
    step();
    checks++; if (imem_rready_o !== 1'b1) begin errors++; $display("FAIL rmid_in_r got=%b exp=1", imem_rready_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_rready_o !== 1'b0 || imem_arvalid_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_addr_o !== 32'h8000_0000) begin
      errors++; $display("FAIL rmid_async got=%b/%b/%b/%h/%h exp=0/0/0/0/80000000", imem_rready_o, imem_arvalid_o, inst_valid_o, inst_o, inst_addr_o); end
    step();
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0293;
    step();
    checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h8000_0000) begin
      errors++; $display("FAIL rmid_refetch got=%b/%h exp=1/80000000", imem_arvalid_o, imem_araddr_o); end
    step();
    step();
    checks++; if (inst_o !== 32'h0050_0293 || inst_addr_o !== 32'h8000_0000) begin
      errors++; $display("FAIL rmid_out got=%h/%h exp=00500293/80000000", inst_o, inst_addr_o); end
    step();
    checks++; if (imem_araddr_o !== 32'h8000_0004) begin errors++; $display("FAIL rmid_next got=%h exp=80000004", imem_araddr_o); end
  endtask

  task automatic test_misalign();
    step();
    step();
    jump_en_i = 1'b1; jump_addr_i = 32'h8000_0102;
    step();
    jump_en_i = 1'b0;
`ifdef IFU_ALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if (misalign_o !== 1'b1 || imem_arvalid_o !== 1'b0 || imem_rready_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        errors++; $display("FAIL mis_halt%0d got=%b/%b/%b/%b exp=1/0/0/0", i, misalign_o, imem_arvalid_o, imem_rready_o, inst_valid_o); end
      step();
    end
`else
    checks++; if (imem_arvalid_o !== 1'b1 || imem_araddr_o !== 32'h8000_0102 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL mis_verbatim got=%b/%h/%b exp=1/80000102/0", imem_arvalid_o, imem_araddr_o, misalign_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_backpressure();
    test_jump();
    test_err();
    test_wrap();
    test_reset_mid();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
